// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES key-schedule sequencing logic.
//   KEY_W            cipher key width
//   NUM_ROUNDS       number of AES rounds; round keys are indexed 0..NUM_ROUNDS
//   ROUND_IDX_W      width of a round-key index
//   key_ctrl_state_t sequencing controller states
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int KEY_W       = 128;
    localparam int NUM_ROUNDS  = 10;
    localparam int ROUND_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } key_ctrl_state_t;

endpackage

// File: rtl/key_round_controller_if.sv
// -----------------------------------------------------------------------------
// key_round_controller_if
// Bundles the request/acknowledge and key-schedule signals of the
// key_round_controller.
//   master : transfer-control / datapath side (drives start, decrypt, key_in,
//            dp_ready, abort; observes everything else)
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface key_round_controller_if;
    import aes_pkg::*;

    logic                   start;
    logic                   decrypt;
    logic [KEY_W-1:0]       key_in;
    logic                   dp_ready;
    logic                   abort;

    logic [KEY_W-1:0]       key_reg;
    logic [ROUND_IDX_W-1:0] key_sel;
    logic                   round_valid;
    logic                   first_round;
    logic                   last_round;
    logic                   busy;
    logic                   done;

    modport master (
        output start, decrypt, key_in, dp_ready, abort,
        input  key_reg, key_sel, round_valid, first_round, last_round, busy, done
    );

    modport slave (
        input  start, decrypt, key_in, dp_ready, abort,
        output key_reg, key_sel, round_valid, first_round, last_round, busy, done
    );

endinterface

// File: rtl/aes_round_counter.sv
// -----------------------------------------------------------------------------
// aes_round_counter
// Loadable up/down round-key index counter with enable and terminal flag.
// The terminal value is MAX when counting up and 0 when counting down; the
// counter never steps past it, so the index cannot wrap.
//   clk, n_rst  clock, asynchronous active-low reset (count clears to 0)
//   load        load load_val (has priority over en)
//   load_val    value to load
//   en          step one position toward the terminal value
//   down        direction: 0 = up toward MAX, 1 = down toward 0
//   count       current index
//   term        count equals the terminal value for the current direction
// -----------------------------------------------------------------------------
module aes_round_counter #(
    parameter int MAX = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         down,
    output logic [W-1:0] count,
    output logic         term
);

    assign term = down ? (count == '0) : (count == W'(MAX));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !term) begin
            count <= down ? count - W'(1) : count + W'(1);
        end
    end

endmodule

// File: rtl/key_round_controller.sv
// -----------------------------------------------------------------------------
// key_round_controller
// Latches a cipher key on start, then walks the key scheduler's round-key
// select through every round key (forward for encryption, reverse for
// decryption), advancing one key per datapath acknowledge.
//   clk      system clock, rising edge
//   n_rst    asynchronous active-low reset
//   bus      key_round_controller_if.slave:
//              in : start, decrypt, key_in, dp_ready, abort
//              out: key_reg, key_sel, round_valid, first_round, last_round,
//                   busy, done
// All outputs are registers or decodes of registered state.
// -----------------------------------------------------------------------------
module key_round_controller
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic                   clk,
    input  logic                   n_rst,
    key_round_controller_if.slave  bus
);

    localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(NUM_ROUNDS);

    key_ctrl_state_t        state;
    key_ctrl_state_t        state_next;
    logic [KEY_W-1:0]       key_q;
    logic                   mode_q;      // 1 = decrypt (reverse key order)
    logic [ROUND_IDX_W-1:0] sel;
    logic                   term;
    logic                   accept;
    logic                   step;
    logic [ROUND_IDX_W-1:0] start_idx;

    // start is only honoured in IDLE, and abort wins over it.
    assign accept = (state == ST_IDLE) && bus.start && !bus.abort;
    assign step   = (state == ST_RUN) && bus.dp_ready && !bus.abort;

    // Starting index of the latched mode, used to flag the initial key.
    assign start_idx = mode_q ? LAST_IDX : '0;

    aes_round_counter #(
        .MAX (NUM_ROUNDS),
        .W   (ROUND_IDX_W)
    ) u_round_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (accept),
        .load_val (bus.decrypt ? LAST_IDX : '0),
        .en       (step),
        .down     (mode_q),
        .count    (sel),
        .term     (term)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_q  <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            key_q  <= bus.key_in;
            mode_q <= bus.decrypt;
        end
    end

    // NOTE: next-state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept) state_next = ST_LOAD;
            ST_LOAD: state_next = bus.abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (bus.dp_ready && term) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.key_reg     = key_q;
    assign bus.key_sel     = sel;
    assign bus.round_valid = (state == ST_RUN);
    assign bus.first_round = (state == ST_RUN) && (sel == start_idx);
    assign bus.last_round  = (state == ST_RUN) && term;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);

endmodule
